// File: rtl/d_flip_flop.sv
// d_flip_flop: parameterized D register / delay line with async active-low reset, enable, sync clear.
// Define D_FLIP_FLOP_EDGE_EN to add per-bit registered rise/fall pulse outputs.
module d_flip_flop #(
    parameter int              WIDTH   = 1,
    parameter int              DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             changed
`ifdef D_FLIP_FLOP_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic             changed_q;
    logic             changed_d;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        stage_d[0] = clr ? RST_VAL : en ? d : stage_q[0];
        for (int k = 1; k < DEPTH; k++)
            stage_d[k] = clr ? RST_VAL : en ? stage_q[k-1] : stage_q[k];
        q_next    = stage_d[DEPTH-1];
        changed_d = q_next != stage_q[DEPTH-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++)
                stage_q[k] <= RST_VAL;
            changed_q <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            changed_q <= changed_d;
        end
    end

    assign q       = stage_q[DEPTH-1];
    assign qn      = ~q;
    assign changed = changed_q;

`ifdef D_FLIP_FLOP_EDGE_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    // Pulses compare the incoming q against the current q, so a clear only flags real transitions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= q_next & ~q;
            fall_q <= ~q_next & q;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`endif
endmodule

// File: tb/tb_d_flip_flop.sv
// tb_d_flip_flop: directed checks of a default flop and an 8-bit, 3-deep delay line.
module tb_d_flip_flop;
    logic       clk = 1'b0;
    logic       rst, en, clr, d0, en1;
    logic [7:0] d1;
    logic       q0, qn0, ch0, ch1;
    logic [7:0] q1, qn1;
    int         total = 0;
    int         bad = 0;
`ifdef D_FLIP_FLOP_EDGE_EN
    logic       rise0, fall0;
    logic [7:0] rise1, fall1;
`endif

    always #5 clk = ~clk;

    d_flip_flop u0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d0),
        .q(q0), .qn(qn0), .changed(ch0)
`ifdef D_FLIP_FLOP_EDGE_EN
        , .rise(rise0), .fall(fall0)
`endif
    );

    d_flip_flop #(.WIDTH(8), .DEPTH(3)) u1 (
        .clk(clk), .rst(rst), .en(en1), .clr(clr), .d(d1),
        .q(q1), .qn(qn1), .changed(ch1)
`ifdef D_FLIP_FLOP_EDGE_EN
        , .rise(rise1), .fall(fall1)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; clr = 1'b0; d0 = 1'b0; en1 = 1'b0; d1 = 8'h00;
        #2;
        check("rst_q", q0, 0);
        check("rst_qn", qn0, 1);
        check("rst_ch", ch0, 0);
        check("rst_q1", q1, 0);
        check("rst_qn1", qn1, 8'hFF);
        @(negedge clk);
        rst = 1'b1; d0 = 1'b1;
        tick();
        check("load_q", q0, 1);
        check("load_qn", qn0, 0);
        check("load_ch", ch0, 1);
        d0 = 1'b0;
        tick();
        check("load0_q", q0, 0);
        check("load0_ch", ch0, 1);
        tick();
        check("steady_ch", ch0, 0);
        d0 = 1'b1;
        tick();
        check("pre_rst_q", q0, 1);
        #2 rst = 1'b0;
        #1;
        check("async_q", q0, 0);
        check("async_qn", qn0, 1);
        check("async_ch", ch0, 0);
        tick();
        check("hold_rst_q", q0, 0);
        d0 = 1'b0;
        #2 rst = 1'b1;
        tick();
        check("rel_q", q0, 0);
        d0 = 1'b1;
        tick();
        check("rel_load_q", q0, 1);
        en = 1'b0; d0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("en_hold_q", q0, 1);
        end
        check("en_hold_ch", ch0, 0);
        clr = 1'b1; en = 1'b1; d0 = 1'b1;
        tick();
        check("clr_q", q0, 0);
        check("clr_ch", ch0, 1);
        clr = 1'b0;
        tick();
        check("post_clr_q", q0, 1);
        d0 = 1'b0;
        #3 d0 = 1'b1;
        tick();
        check("glitch_q", q0, 1);
        en1 = 1'b1; d1 = 8'hA5;
        tick();
        check("pipe_e1", q1, 0);
        d1 = 8'h3C;
        tick();
        check("pipe_e2", q1, 0);
        d1 = 8'hFF;
        tick();
        check("pipe_a5", q1, 8'hA5);
        check("pipe_ch", ch1, 1);
        en1 = 1'b0; d1 = 8'h00;
        tick();
        check("gap1", q1, 8'hA5);
        tick();
        check("gap2", q1, 8'hA5);
        check("gap_ch", ch1, 0);
        en1 = 1'b1; d1 = 8'h11;
        tick();
        check("pipe_3c", q1, 8'h3C);
        tick();
        check("pipe_ff", q1, 8'hFF);
        tick();
        check("pipe_11", q1, 8'h11);
        check("pipe_qn", qn1, 8'hEE);
`ifdef D_FLIP_FLOP_EDGE_EN
        d0 = 1'b0;
        tick();
        check("fall_p", fall0, 1);
        check("fall_r", rise0, 0);
        tick();
        check("fall_end", fall0, 0);
        d0 = 1'b1;
        tick();
        check("rise_p", rise0, 1);
        check("rise_f", fall0, 0);
        tick();
        check("rise_end", rise0, 0);
        d0 = 1'b0;
        tick();
        #2 rst = 1'b0;
        #1;
        check("rst_fall", fall0, 0);
        check("rst_rise", rise0, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/d_flip_flop.md
# d_flip_flop

Parameterized D-type register stage with asynchronous active-low reset, clock enable and synchronous clear, configurable as a single flop or a short delay line. It is the basic storage/retiming element in the datapath. In its default configuration (WIDTH=1, DEPTH=1, en tied high, clr tied low) it behaves as a plain D flip-flop. It also provides a complementary output and a change flag.

## Interface
- WIDTH, 1, data width in bits (1..64).
- DEPTH, 1, number of register stages between d and q (1..8).
- RST_VAL, 0, value (WIDTH bits) loaded into every stage on reset or clear.

Ports. Clocking: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (rst=0 resets).
- en  input  1  clock enable; stages advance only when high.
- clr  input  1  synchronous clear to RST_VAL, active-high.
- d  input  WIDTH  data in.
- q  output  WIDTH  data out (last stage).
- qn  output  WIDTH  bitwise complement of q.
- changed  output  1  high for one cycle after q takes a value different from its previous value.

## Operation
- Internal pipeline stage[0..DEPTH-1]; q = stage[DEPTH-1]; qn = ~q, combinational from q.
- Priority on each rising clk edge: rst low > clr > en > hold.
- rst low: all stages = RST_VAL and changed = 0 immediately, independent of clk. The block holds this state while rst is low.
- clr=1 (rst high): all stages = RST_VAL at the edge, regardless of en.
- en=1, clr=0: stage[0] <= d; stage[k] <= stage[k-1].
- en=0, clr=0: all stages hold.
- changed: registered. It is set to 1 at any edge where the new q differs from the current q (including via clr), and 0 otherwise.
- Reset values: q = RST_VAL, qn = ~RST_VAL, changed = 0 (plus rise = fall = 0 when configured).

## Timing
- Latency: d sampled at an enabled edge appears on q after DEPTH enabled edges. For DEPTH=1, q updates at the same edge that samples d.
- Enable gaps stretch latency; no data is lost or duplicated while en=0.
- Reset assertion is asynchronous: q reaches RST_VAL within the same time step, with no clock edge required.
- Reset deassertion: the first edge with rst high is a normal edge and may load d.
- clr and en asserted together: clr wins, and d is discarded for that edge.
- Inputs must be stable around the rising clk edge; the block contains no synchronization.
- d changing between edges has no effect on q.

## Configuration
- D_FLIP_FLOP_EDGE_EN defined: adds outputs rise [WIDTH] and fall [WIDTH].
  - rise[i] is a one-cycle registered pulse when q[i] goes 0->1.
  - fall[i] is a one-cycle registered pulse when q[i] goes 1->0.
  - Both are cleared by rst and are 0 after clr unless q actually transitioned.
- D_FLIP_FLOP_EDGE_EN not defined: rise/fall ports and their logic are absent; all other behaviour is identical.

## Test plan
Default parameters, 10-unit clock period, en=1, clr=0 unless stated.
- Reset at start: rst=0, d=0 -> q=0, qn=1, changed=0 before any clock edge.
- Release and load: rst=1, d=1 -> q=1 after the next rising edge, changed=1 for one cycle. d=0 -> q=0 at the following edge.
- Reset mid-operation: with q=1, drive rst=0 between edges -> q=0 immediately, staying 0 while rst=0 even with d=1. Release rst with d=0, then d=1 -> q=1 one edge after d rises.
- Enable/clear: q=1, en=0, d=0 -> q holds 1 for 3 edges. clr=1 together with en=1 and d=1 -> q=RST_VAL (0) at the next edge.
- Pipeline: WIDTH=8, DEPTH=3, apply d=0xA5, 0x3C, 0xFF on consecutive edges -> q shows 0xA5, 0x3C, 0xFF starting 3 edges after the first load. Deassert en for 2 cycles mid-stream -> the sequence is delayed by 2, with no loss.
- With D_FLIP_FLOP_EDGE_EN: d toggles 0->1->0 -> one-cycle rise pulse, then one-cycle fall pulse, each aligned with the q change. With rst=0, both are 0.
